// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC fetch datapath: opcodes, status bit positions
// and the fetch FSM state encoding.
package sisc_pkg;

    localparam logic [3:0] OP_NOOP = 4'h0;
    localparam logic [3:0] OP_LOD  = 4'h1;
    localparam logic [3:0] OP_STR  = 4'h2;
    localparam logic [3:0] OP_SWP  = 4'h3;
    localparam logic [3:0] OP_BRA  = 4'h4;
    localparam logic [3:0] OP_BRR  = 4'h5;
    localparam logic [3:0] OP_BNE  = 4'h6;
    localparam logic [3:0] OP_BNR  = 4'h7;
    localparam logic [3:0] OP_ALU  = 4'h8;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam int STAT_C = 3;
    localparam int STAT_V = 2;
    localparam int STAT_N = 1;
    localparam int STAT_Z = 0;

    typedef enum logic [0:0] {
        FS_IDLE = 1'b0,
        FS_REQ  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/sisc_fetch_unit_if.sv
// Instruction-memory fetch bus between the fetch unit (master) and memory (slave).
interface sisc_fetch_unit_if #(
    parameter int AW = 8,
    parameter int IW = 32
);
    logic [AW-1:0] im_addr;
    logic          im_req;
    logic          im_ack;
    logic [IW-1:0] im_data;

    modport master (output im_addr, output im_req, input im_ack, input im_data);
    modport slave  (input im_addr, input im_req, output im_ack, output im_data);
endinterface

// File: rtl/sisc_br_eval.sv
// Combinational branch evaluator: decides taken/target from the current
// instruction fields, status register and program counter.
module sisc_br_eval
    import sisc_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic [3:0]    opcode,
    input  logic [3:0]    mm,
    input  logic [3:0]    stat,
    input  logic [AW-1:0] pc,
    input  logic [15:0]   imm16,
    output logic          taken,
    output logic [AW-1:0] target
);

    logic                 cond_hit;
    logic                 cond_miss;
    logic signed [AW-1:0] rel_off;
    logic        [AW-1:0] abs_tgt;

    assign cond_hit  = (mm == 4'd0) || (|(mm & stat));
    assign cond_miss = ((mm & stat) == 4'd0);
    assign rel_off   = AW'($signed(imm16));
    assign abs_tgt   = AW'(imm16);

    always_comb begin
        taken  = 1'b0;
        target = abs_tgt;
        unique case (opcode)
            OP_BRA: taken = cond_hit;
            OP_BRR: begin
                taken  = cond_hit;
                target = pc + rel_off;
            end
            OP_BNE: taken = cond_miss;
            OP_BNR: begin
                taken  = cond_miss;
                target = pc + rel_off;
            end
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC fetch unit: PC, IR and status register plus the instruction fetch handshake.
// Optional fetch timeout enabled by defining SISC_FETCH_TIMEOUT_EN.
module sisc_fetch_unit
    import sisc_pkg::*;
#(
    parameter int AW          = 8,
    parameter int IW          = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                  clk,
    input  logic                  rst_f,
    input  logic                  fetch_go,
    sisc_fetch_unit_if.master     im,
    output logic [IW-1:0]         ir,
    output logic [3:0]            opcode,
    output logic [3:0]            mm,
    output logic                  fetch_done,
    input  logic                  pc_write,
    input  logic [3:0]            alu_flags,
    input  logic                  stat_en,
    output logic [3:0]            stat,
    output logic [AW-1:0]         pc,
    output logic                  fetch_err
);

    fetch_state_e  state_q, state_d;
    logic          load_ir;
    logic [AW-1:0] addr_q;
    logic          br_taken;
    logic [AW-1:0] br_target;

    assign opcode     = ir[31:28];
    assign mm         = ir[27:24];
    assign im.im_req  = (state_q == FS_REQ);
    assign im.im_addr = addr_q;

    sisc_br_eval #(.AW(AW)) u_br_eval (
        .opcode (opcode),
        .mm     (mm),
        .stat   (stat),
        .pc     (pc),
        .imm16  (ir[15:0]),
        .taken  (br_taken),
        .target (br_target)
    );

`ifdef SISC_FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_hit;

    assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
`endif

    always_comb begin
        state_d = state_q;
        load_ir = 1'b0;
        unique case (state_q)
            FS_IDLE: if (fetch_go) state_d = FS_REQ;
            FS_REQ: begin
                if (im.im_ack) begin
                    state_d = FS_IDLE;
                    load_ir = 1'b1;
                end
`ifdef SISC_FETCH_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = FS_IDLE;
                end
`endif
            end
            default: state_d = FS_IDLE;
        endcase
    end

    // The fetch address is captured when the request is launched so a PC
    // commit on the same edge cannot move it.
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q    <= FS_IDLE;
            ir         <= '0;
            stat       <= '0;
            pc         <= '0;
            addr_q     <= '0;
            fetch_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_done <= load_ir;
            if (load_ir)
                ir <= im.im_data;
            if (state_q == FS_IDLE && fetch_go)
                addr_q <= pc;
            if (stat_en)
                stat <= alu_flags;
            if (pc_write && state_q != FS_REQ)
                pc <= br_taken ? br_target : pc + AW'(1);
        end
    end

`ifdef SISC_FETCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            tmo_cnt_q <= '0;
            fetch_err <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == FS_REQ) ? tmo_cnt_q + TW'(1) : '0;
            if (state_q == FS_REQ && !im.im_ack && tmo_hit)
                fetch_err <= 1'b1;
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Self-checking bench for sisc_fetch_unit: table-driven branch vectors plus
// directed fetch, reset and timeout sequences (honours SISC_FETCH_TIMEOUT_EN).
module tb_sisc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_f;
    logic        fetch_go;
    logic [31:0] ir;
    logic [3:0]  opcode, mm, alu_flags, stat;
    logic        fetch_done, pc_write, stat_en, fetch_err;
    logic [7:0]  pc;

    int checks = 0;
    int errors = 0;

    sisc_fetch_unit_if #(.AW(8), .IW(32)) imb ();

    sisc_fetch_unit #(.AW(8), .IW(32), .TIMEOUT_CYC(15)) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .fetch_go   (fetch_go),
        .im         (imb),
        .ir         (ir),
        .opcode     (opcode),
        .mm         (mm),
        .fetch_done (fetch_done),
        .pc_write   (pc_write),
        .alu_flags  (alu_flags),
        .stat_en    (stat_en),
        .stat       (stat),
        .pc         (pc),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pc0;
        logic [31:0] instr;
        logic [3:0]  st;
        logic [7:0]  exp_pc;
    } br_vec_t;

    br_vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_f = 1'b0;
        tick();
        rst_f = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] data);
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        imb.im_ack  = 1'b1;
        imb.im_data = data;
        tick();
        imb.im_ack  = 1'b0;
        chk("fetch_done_pulse", {31'd0, fetch_done}, 32'd1);
        tick();
    endtask

    task automatic pc_commit();
        pc_write = 1'b1;
        tick();
        pc_write = 1'b0;
    endtask

    task automatic load_stat(input logic [3:0] v);
        stat_en   = 1'b1;
        alu_flags = v;
        tick();
        stat_en   = 1'b0;
    endtask

    task automatic set_pc(input logic [7:0] v);
        fetch({24'h4000_00, v});
        pc_commit();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{8'h00, 32'h4200_0010, 4'b0010, 8'h10};
        vecs[1]  = '{8'h00, 32'h4200_0010, 4'b0001, 8'h01};
        vecs[2]  = '{8'h02, 32'h7100_FFFC, 4'b0000, 8'hFE};
        vecs[3]  = '{8'hFF, 32'h0000_0000, 4'b0000, 8'h00};
        vecs[4]  = '{8'h10, 32'h5800_0005, 4'b1000, 8'h15};
        vecs[5]  = '{8'h10, 32'h5800_0005, 4'b0111, 8'h11};
        vecs[6]  = '{8'h20, 32'h6300_0042, 4'b0100, 8'h42};
        vecs[7]  = '{8'h20, 32'h6300_0042, 4'b0001, 8'h21};
        vecs[8]  = '{8'h30, 32'h4000_0099, 4'b0000, 8'h99};
        vecs[9]  = '{8'hF0, 32'h5F00_0020, 4'b0001, 8'h10};
        vecs[10] = '{8'h40, 32'hF000_0000, 4'b1111, 8'h41};
        vecs[11] = '{8'h50, 32'h6000_0011, 4'b1111, 8'h11};
        vecs[12] = '{8'h10, 32'h7200_0123, 4'b0010, 8'h11};
        vecs[13] = '{8'h80, 32'h4100_01AB, 4'b0001, 8'hAB};

        rst_f = 1'b0; fetch_go = 1'b0; pc_write = 1'b0; stat_en = 1'b0;
        alu_flags = 4'd0; imb.im_ack = 1'b0; imb.im_data = 32'd0;
        tick(); tick();
        rst_f = 1'b1;

        chk("rst_pc", {24'd0, pc}, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_stat", {28'd0, stat}, 32'd0);
        chk("rst_im_req", {31'd0, imb.im_req}, 32'd0);
        chk("rst_fetch_done", {31'd0, fetch_done}, 32'd0);
        chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);

        // Fetch with ack three cycles after fetch_go, at pc 0x05.
        for (int i = 0; i < 5; i++) pc_commit();
        chk("pc_step", {24'd0, pc}, 32'h05);
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        chk("req_high", {31'd0, imb.im_req}, 32'd1);
        chk("req_addr", {24'd0, imb.im_addr}, 32'h05);
        pc_write = 1'b1;
        tick();
        pc_write = 1'b0;
        chk("pc_frozen_in_req", {24'd0, pc}, 32'h05);
        chk("no_done_early", {31'd0, fetch_done}, 32'd0);
        tick();
        chk("addr_stable", {24'd0, imb.im_addr}, 32'h05);
        imb.im_ack = 1'b1; imb.im_data = 32'h4200_0010;
        tick();
        imb.im_ack = 1'b0;
        chk("done_at_n4", {31'd0, fetch_done}, 32'd1);
        chk("ir_loaded", ir, 32'h4200_0010);
        chk("opcode", {28'd0, opcode}, 32'd4);
        chk("mm", {28'd0, mm}, 32'd2);
        tick();
        chk("done_single", {31'd0, fetch_done}, 32'd0);
        chk("req_dropped", {31'd0, imb.im_req}, 32'd0);
        imb.im_ack = 1'b1; imb.im_data = 32'hDEAD_BEEF;
        tick();
        imb.im_ack = 1'b0;
        chk("ack_idle_ir", ir, 32'h4200_0010);
        chk("ack_idle_done", {31'd0, fetch_done}, 32'd0);

        // Branch vector table.
        for (int i = 0; i < 14; i++) begin
            do_reset();
            set_pc(vecs[i].pc0);
            fetch(vecs[i].instr);
            load_stat(vecs[i].st);
            pc_commit();
            chk($sformatf("br_vec%0d", i), {24'd0, pc}, {24'd0, vecs[i].exp_pc});
        end

        // stat_en and pc_write together: branch sees the old stat.
        do_reset();
        set_pc(8'h33);
        fetch(32'h4100_0000);
        load_stat(4'b0000);
        stat_en = 1'b1; alu_flags = 4'b0001; pc_write = 1'b1;
        tick();
        stat_en = 1'b0; pc_write = 1'b0;
        chk("same_edge_pc", {24'd0, pc}, 32'h34);
        chk("same_edge_stat", {28'd0, stat}, 32'h1);

        // Reset during an outstanding request.
        set_pc(8'h21);
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        rst_f = 1'b0;
        tick();
        chk("midreq_rst_req", {31'd0, imb.im_req}, 32'd0);
        chk("midreq_rst_pc", {24'd0, pc}, 32'd0);
        chk("midreq_rst_done", {31'd0, fetch_done}, 32'd0);
        rst_f = 1'b1;
        imb.im_ack = 1'b1; imb.im_data = 32'h1234_5678;
        tick();
        imb.im_ack = 1'b0;
        chk("midreq_late_ack", {31'd0, fetch_done}, 32'd0);
        chk("midreq_ir", ir, 32'd0);

        // No ack at all: timeout behaviour depends on the build.
        do_reset();
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("tmo_req_14", {31'd0, imb.im_req}, 32'd1);
        chk("tmo_err_14", {31'd0, fetch_err}, 32'd0);
        tick();
`ifdef SISC_FETCH_TIMEOUT_EN
        chk("tmo_req_15", {31'd0, imb.im_req}, 32'd0);
        chk("tmo_err_15", {31'd0, fetch_err}, 32'd1);
        chk("tmo_no_done", {31'd0, fetch_done}, 32'd0);
        chk("tmo_ir_kept", ir, 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("tmo_err_sticky", {31'd0, fetch_err}, 32'd1);
`else
        for (int i = 0; i < 5; i++) tick();
        chk("notmo_req_held", {31'd0, imb.im_req}, 32'd1);
        chk("notmo_err", {31'd0, fetch_err}, 32'd0);
`endif
        do_reset();
        chk("final_rst_err", {31'd0, fetch_err}, 32'd0);
        chk("final_rst_req", {31'd0, imb.im_req}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
